// File: rtl/hs_tx_encoder.sv
// USB2 HS transmit encoder: byte handshake in, SYNC + bit-stuffed NRZI data + EOP out,
// one line bit per clock_480 cycle. Registers always hold the bit currently on the line.
module hs_tx_encoder #(
  parameter int SYNC_BITS = 32,
  parameter int EOP_BITS  = 8,
  parameter int STUFF_RUN = 6
) (
  input  logic       clock_480,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data_in,
  output logic       tx_ready,
  output logic       tx_line,
  output logic       tx_en,
  output logic       busy
);
  localparam int CW = $clog2((SYNC_BITS > EOP_BITS ? SYNC_BITS : EOP_BITS) + 1);
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_BITS - 1);
  localparam logic [CW-1:0] SYNC_PREV = CW'(SYNC_BITS - 2);
  localparam logic [CW-1:0] EOP_LAST  = CW'(EOP_BITS - 1);
  localparam logic [OW-1:0] RUN       = OW'(STUFF_RUN);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic [3:0]      rem_q, rem_d;
  logic [OW-1:0]   ones_q, ones_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            line_q, line_d;
  logic            en_q, en_d;
  logic            busy_q, busy_d;
  logic            active, need_byte, stuff_now, end_now, emit, bit_out;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    ones_d      = ones_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    line_d      = line_q;
    en_d        = en_q;
    busy_d      = busy_q;
    emit        = 1'b0;
    bit_out     = 1'b0;

    active    = (state_q == SYNC) || (state_q == DATA);
    need_byte = ((state_q == SYNC) && (cnt_q == SYNC_LAST)) ||
                ((state_q == DATA) && (rem_q == 4'd0));
    stuff_now = active && (ones_q == RUN);
    // A byte showing up in the very cycle the shifter runs dry is too late.
    end_now   = need_byte && !stuff_now && !hold_full_q;
    tx_ready  = tx_valid && active && !hold_full_q && !end_now;

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = SYNC;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          emit    = 1'b1;
        end
      end
      SYNC, DATA: begin
        emit = 1'b1;
        if (stuff_now) begin
          bit_out = 1'b0;
        end else if (need_byte) begin
          if (hold_full_q) begin
            state_d     = DATA;
            bit_out     = hold_q[0];
            sh_d        = {1'b0, hold_q[7:1]};
            rem_d       = 4'd7;
            hold_full_d = 1'b0;
          end else begin
            state_d = EOP;
            cnt_d   = '0;
          end
        end else if (state_q == SYNC) begin
          cnt_d   = cnt_q + CW'(1);
          bit_out = (cnt_q == SYNC_PREV);
        end else begin
          bit_out = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          rem_d   = rem_q - 4'd1;
        end
      end
      EOP: begin
        if (cnt_q == EOP_LAST) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          line_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          emit    = 1'b1;
          bit_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI: a data zero toggles the line; the ones run feeds the stuffing decision.
    if (emit) begin
      line_d = bit_out ? line_q : ~line_q;
      ones_d = bit_out ? ones_q + OW'(1) : '0;
    end

    if (tx_ready) begin
      hold_d      = tx_data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock_480 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      rem_q       <= '0;
      ones_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      line_q      <= 1'b1;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      ones_q      <= ones_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      line_q      <= line_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_line = line_q;
  assign tx_en   = en_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_hs_tx_encoder.sv
// Bench for hs_tx_encoder: packets are planned as bit lists (SYNC, stuffed data, EOP),
// NRZI-expanded into per-cycle expectations and compared every cycle.
module tb_hs_tx_encoder;
  localparam int SB = 32, EB = 8, SR = 6, MAXC = 16384;

  logic       clk = 0, rst = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       tx_ready, tx_line, tx_en, busy;

  hs_tx_encoder dut (
    .clock_480(clk), .reset(rst), .tx_valid(tx_valid), .tx_data_in(tx_data),
    .tx_ready(tx_ready), .tx_line(tx_line), .tx_en(tx_en), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0, total = 0, bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit         exp_line[MAXC], exp_en[MAXC], exp_busy[MAXC], exp_rdy[MAXC];
  bit         drv_v[MAXC], act_line[MAXC];
  logic [7:0] drv_d[MAXC];
  bit         chk_on = 0, auto_drv = 0;
  logic [7:0] pb[64];
  int         pg[64];
  logic [7:0] stream[64];
  int         nxt, last_s, last_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Build the packet as a bit list, derive host timing from byte eligibility windows.
  task automatic plan(input int s, input int n, output int t);
    bit bits[$];
    int ones, a, start, need, v, k, late_v;
    logic [7:0] cur;
    bit lvl;
    late_v = -1;
    for (int i = 0; i < SB - 1; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    ones = 1;
    drv_v[s-1] = 1; drv_d[s-1] = pb[0];
    drv_v[s]   = 1; drv_d[s]   = pb[0];
    exp_rdy[s] = 1;
    a = 0; k = 0; start = 0;
    forever begin
      cur = pb[k];
      for (int j = 0; j < 8; j++) begin
        if (ones == SR) begin bits.push_back(1'b0); ones = 0; end
        if (j == 0) start = bits.size();
        bits.push_back(cur[j]);
        ones = cur[j] ? ones + 1 : 0;
      end
      if (ones == SR) begin bits.push_back(1'b0); ones = 0; end
      need = bits.size() - 1;
      if (k + 1 >= n) break;
      v = a + 1 + pg[k+1];
      a = (v > start) ? v : start;
      if (a > need - 1) begin late_v = v; break; end
      for (int c = v; c <= a; c++) begin drv_v[s+c] = 1; drv_d[s+c] = pb[k+1]; end
      exp_rdy[s+a] = 1;
      k++;
    end
    bits.push_back(1'b0);
    for (int i = 1; i < EB; i++) bits.push_back(1'b1);
    t = bits.size();
    if (late_v >= 0)
      for (int c = late_v; c < t; c++) begin drv_v[s+c] = 1; drv_d[s+c] = pb[k+1]; end
    lvl = 1'b1;
    for (int i = 0; i < t; i++) begin
      if (!bits[i]) lvl = ~lvl;
      exp_line[s+i] = lvl; exp_en[s+i] = 1; exp_busy[s+i] = 1;
    end
  endtask

  task automatic go(input int n);
    plan(nxt, n, last_t);
    last_s = nxt;
    nxt = nxt + last_t + 1 + $urandom_range(0, 3);
  endtask

  task automatic zero_gaps();
    for (int i = 0; i < 64; i++) pg[i] = 0;
  endtask

  task automatic reset_test(input int k, input string nm);
    @(posedge clk); #1;
    tx_valid = 1; tx_data = 8'hA5;
    repeat (k) @(posedge clk);
    #2;
    chk({nm, "_pre_busy"}, busy, 1);
    rst = 1; #1;
    chk({nm, "_line"}, tx_line, 1);
    chk({nm, "_en"}, tx_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_ready"}, tx_ready, 0);
    tx_valid = 0;
    @(negedge clk); rst = 0;
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (auto_drv && cyc < MAXC) begin tx_valid = drv_v[cyc]; tx_data = drv_d[cyc]; end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on && cyc < MAXC) begin
      act_line[cyc] = tx_line;
      chk("tx_line", tx_line, exp_line[cyc]);
      chk("tx_en", tx_en, exp_en[cyc]);
      chk("busy", busy, exp_busy[cyc]);
      chk("tx_ready", tx_ready, exp_rdy[cyc]);
    end
  end

  initial begin
    int s64, t64, e, ones, lvl_i;
    logic [7:0] v8;
    bit d, lvl;
    bit bq[$];
    for (int c = 0; c < MAXC; c++) begin exp_line[c] = 1; drv_d[c] = 8'h00; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", tx_line, 1);
    chk("rst_en", tx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 0;
    reset_test(10, "rst_sync");
    reset_test(45, "rst_data");

    @(posedge clk); #1;
    nxt = cyc + 2;

    zero_gaps(); pb[0] = 8'h00; go(1);
    chk("pin_len00", last_t, 48);
    chk("pin_sync_first", exp_line[last_s], 0);
    chk("pin_sync_last", exp_line[last_s+31], 0);
    for (int i = 0; i < 8; i++) v8[7-i] = exp_line[last_s+32+i];
    chk("pin_data00", v8, 8'hAA);
    for (int i = 0; i < 8; i++) v8[7-i] = exp_line[last_s+40+i];
    chk("pin_eop", v8, 8'hFF);

    zero_gaps(); pb[0] = 8'hFF; pb[1] = 8'hFF; go(2);
    chk("pin_lenFF", last_t, 58);
    zero_gaps(); pb[0] = 8'hF8; pb[1] = 8'h07; go(2);
    chk("pin_len_cross", last_t, 57);
    zero_gaps(); pb[0] = 8'h7E; pb[1] = 8'h3F; go(2);
    chk("pin_len7E3F", last_t, 58);

    zero_gaps(); for (int i = 0; i < 4; i++) pb[i] = 8'h00;
    pg[2] = 20; go(4);
    chk("pin_underrun_len", last_t, 56);
    chk("pin_underrun_offer", drv_v[last_s+54], 1);

    zero_gaps();
    for (int i = 0; i < 64; i++) begin
      pb[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      stream[i] = pb[i];
    end
    go(64);
    s64 = last_s; t64 = last_t;

    for (int p = 0; p < 20; p++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        pb[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        pg[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 20) : $urandom_range(0, 4);
      end
      go(n);
    end
    e = nxt;

    auto_drv = 1; chk_on = 1;
    repeat (e - cyc + 3) @(posedge clk);
    @(negedge clk); chk_on = 0;

    // Independent decode of the long stream from the captured line.
    lvl = 1'b1; ones = 0;
    for (int i = 0; i < t64 - EB; i++) begin
      lvl_i = act_line[s64+i];
      d = (lvl_i == lvl);
      lvl = lvl_i[0];
      if (i < SB) begin ones = (i == SB - 1) ? 1 : 0; continue; end
      if (ones == SR) begin ones = 0; continue; end
      ones = d ? ones + 1 : 0;
      bq.push_back(d);
    end
    chk("decode_len", bq.size(), 512);
    for (int k = 0; k < 64; k++) begin
      for (int j = 0; j < 8; j++) v8[j] = (8*k + j < bq.size()) ? bq[8*k+j] : 1'b0;
      chk("decode_byte", v8, stream[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
